// File: rtl/exec_pkg.sv
// Shared types and helpers for the execute-stage functional-unit sequencer.
// Unit selects are widened to MAX_FU bits before they reach the helpers.
package exec_pkg;

   localparam int MAX_FU    = 32;
   localparam int MAX_IDX_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   function automatic logic is_onehot(input logic [MAX_FU-1:0] v);
      return (v != '0) && ((v & (v - MAX_FU'(1))) == '0);
   endfunction

   // OR-encoder: the result is only meaningful when v is one-hot.
   function automatic logic [MAX_IDX_W-1:0] onehot_index(input logic [MAX_FU-1:0] v);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_FU; i++) begin
         if (v[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/exec_fu_sequencer_if.sv
// Issue, functional-unit and completion signals of the execute-stage sequencer.
// The slave modport is the sequencer; the master modport drives it.
interface exec_fu_sequencer_if #(
   parameter int NUM_FU = 4,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
);
   logic                     issue_valid_i;
   logic                     issue_ready_o;
   logic [NUM_FU-1:0]        issue_fu_sel_i;
   logic [TAG_W-1:0]         issue_tag_i;
   logic                     issue_excp_i;
   logic                     flush_i;
   logic [NUM_FU-1:0]        fu_start_o;
   logic [NUM_FU-1:0]        fu_done_i;
   logic [NUM_FU*DATA_W-1:0] fu_result_i;
   logic                     done_valid_o;
   logic                     done_ready_i;
   logic [TAG_W-1:0]         done_tag_o;
   logic [DATA_W-1:0]        done_result_o;
   logic [NUM_FU-1:0]        done_fu_o;
   logic                     done_excp_o;
   logic                     done_timeout_o;
   logic                     busy_o;

   modport slave (
      input  issue_valid_i, issue_fu_sel_i, issue_tag_i, issue_excp_i, flush_i,
             fu_done_i, fu_result_i, done_ready_i,
      output issue_ready_o, fu_start_o, done_valid_o, done_tag_o, done_result_o,
             done_fu_o, done_excp_o, done_timeout_o, busy_o
   );

   modport master (
      output issue_valid_i, issue_fu_sel_i, issue_tag_i, issue_excp_i, flush_i,
             fu_done_i, fu_result_i, done_ready_i,
      input  issue_ready_o, fu_start_o, done_valid_o, done_tag_o, done_result_o,
             done_fu_o, done_excp_o, done_timeout_o, busy_o
   );

endinterface

// File: rtl/exec_timeout_counter.sv
// Watchdog counter: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT. TIMEOUT = 0 disables expiry.
module exec_timeout_counter #(
   parameter int TIMEOUT = 255,
   parameter int TMO_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

   logic [TMO_W-1:0] count_q, count_d;

   // Saturate so a disabled watchdog never wraps back into range.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (TIMEOUT != 0) && en_i && (count_q == LAST);

endmodule

// File: rtl/exec_fu_sequencer.sv
// Execute-stage sequencer: issues one instruction to one of NUM_FU units,
// waits for its done (with watchdog), and holds the result on a valid/ready port.
module exec_fu_sequencer
   import exec_pkg::*;
#(
   parameter int NUM_FU  = 4,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 255,
   parameter int TMO_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   exec_fu_sequencer_if.slave bus
);
   localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   state_e              state_q, state_d;
   logic [NUM_FU-1:0]   sel_q, sel_d;
   logic [NUM_FU-1:0]   start_q, start_d;
   logic [NUM_FU-1:0]   fu_q, fu_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                valid_q, valid_d;
   logic                excp_q, excp_d;
   logic                tmo_q, tmo_d;
   logic                busy_q, busy_d;

   logic [DATA_W-1:0]   res_arr [NUM_FU];
   logic [IDX_W-1:0]    sel_idx;
   logic                issue_ready;
   logic                accept;
   logic                fu_hit;
   logic                sel_onehot;
   logic                cnt_clr;
   logic                cnt_en;
   logic                expire;

   for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_res
      assign res_arr[gi] = bus.fu_result_i[gi*DATA_W +: DATA_W];
   end

   assign sel_idx     = IDX_W'(onehot_index(MAX_FU'(sel_q)));
   assign sel_onehot  = is_onehot(MAX_FU'(bus.issue_fu_sel_i));
   assign fu_hit      = |(bus.fu_done_i & sel_q);
   // A completion being consumed frees the slot in the same cycle.
   assign issue_ready = !rst && !bus.flush_i &&
                        ((state_q == ST_IDLE) ||
                         ((state_q == ST_HOLD) && bus.done_ready_i));
   assign accept      = bus.issue_valid_i && issue_ready;

   exec_timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .TMO_W   (TMO_W)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (cnt_clr),
      .en_i     (cnt_en),
      .expire_o (expire)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      tag_d    = tag_q;
      start_d  = '0;
      valid_d  = valid_q;
      result_d = result_q;
      fu_d     = fu_q;
      excp_d   = excp_q;
      tmo_d    = tmo_q;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;

      unique case (state_q)
         ST_START, ST_WAIT: begin
            cnt_en = 1'b1;
            if (fu_hit) begin
               state_d  = ST_HOLD;
               valid_d  = 1'b1;
               result_d = res_arr[sel_idx];
               fu_d     = sel_q;
               excp_d   = 1'b0;
               tmo_d    = 1'b0;
            end else if (expire) begin
               state_d  = ST_HOLD;
               valid_d  = 1'b1;
               result_d = '0;
               fu_d     = sel_q;
               excp_d   = 1'b0;
               tmo_d    = 1'b1;
            end else begin
               state_d  = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (bus.done_ready_i) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end
         end
         default: ;
      endcase

      if (accept) begin
         tag_d    = bus.issue_tag_i;
         result_d = '0;
         fu_d     = '0;
         tmo_d    = 1'b0;
         if (bus.issue_excp_i || ((bus.issue_fu_sel_i != '0) && !sel_onehot)) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
            excp_d  = 1'b1;
            sel_d   = '0;
         end else if (bus.issue_fu_sel_i == '0) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
            excp_d  = 1'b0;
            sel_d   = '0;
         end else begin
            state_d = ST_START;
            valid_d = 1'b0;
            excp_d  = 1'b0;
            sel_d   = bus.issue_fu_sel_i;
            start_d = bus.issue_fu_sel_i;
            cnt_clr = 1'b1;
         end
      end

      if (bus.flush_i) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         start_d = '0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         tag_q    <= '0;
         start_q  <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         fu_q     <= '0;
         excp_q   <= 1'b0;
         tmo_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         tag_q    <= tag_d;
         start_q  <= start_d;
         valid_q  <= valid_d;
         result_q <= result_d;
         fu_q     <= fu_d;
         excp_q   <= excp_d;
         tmo_q    <= tmo_d;
         busy_q   <= busy_d;
      end
   end

   // The start pulse is registered but still squashed by a same-cycle flush.
   assign bus.fu_start_o     = start_q & {NUM_FU{!bus.flush_i && !rst}};
   assign bus.issue_ready_o  = issue_ready;
   assign bus.done_valid_o   = valid_q;
   assign bus.done_tag_o     = tag_q;
   assign bus.done_result_o  = result_q;
   assign bus.done_fu_o      = fu_q;
   assign bus.done_excp_o    = excp_q;
   assign bus.done_timeout_o = tmo_q;
   assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_exec_fu_sequencer.sv
// Scoreboard bench: two sequencers (TIMEOUT 255 and 8) share one stimulus stream;
// completions are checked against per-instance expectation queues.
module tb_exec_fu_sequencer;

   typedef struct packed {
      logic [4:0]  tag;
      logic [31:0] res;
      logic [3:0]  fu;
      logic        excp;
      logic        tmo;
   } cpl_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         issue_valid;
   logic [3:0]   issue_sel;
   logic [4:0]   issue_tag;
   logic         issue_excp;
   logic         flush;
   logic [3:0]   fu_done;
   logic [127:0] fu_result;
   logic         done_ready;

   int errors = 0;
   int checks = 0;

   cpl_t q_a[$];
   cpl_t q_b[$];
   cpl_t got_a, exp_a, prev_a;
   cpl_t got_b, exp_b, prev_b;
   logic hold_a = 1'b0;
   logic hold_b = 1'b0;

   always #5 clk = ~clk;

   exec_fu_sequencer_if #(.NUM_FU(4), .DATA_W(32), .TAG_W(5)) bif_a ();
   exec_fu_sequencer_if #(.NUM_FU(4), .DATA_W(32), .TAG_W(5)) bif_b ();

   assign bif_a.issue_valid_i  = issue_valid;
   assign bif_a.issue_fu_sel_i = issue_sel;
   assign bif_a.issue_tag_i    = issue_tag;
   assign bif_a.issue_excp_i   = issue_excp;
   assign bif_a.flush_i        = flush;
   assign bif_a.fu_done_i      = fu_done;
   assign bif_a.fu_result_i    = fu_result;
   assign bif_a.done_ready_i   = done_ready;
   assign bif_b.issue_valid_i  = issue_valid;
   assign bif_b.issue_fu_sel_i = issue_sel;
   assign bif_b.issue_tag_i    = issue_tag;
   assign bif_b.issue_excp_i   = issue_excp;
   assign bif_b.flush_i        = flush;
   assign bif_b.fu_done_i      = fu_done;
   assign bif_b.fu_result_i    = fu_result;
   assign bif_b.done_ready_i   = done_ready;

   exec_fu_sequencer #(.NUM_FU(4), .DATA_W(32), .TAG_W(5), .TIMEOUT(255), .TMO_W(8))
      u_dut_a (.clk(clk), .rst(rst), .bus(bif_a));
   exec_fu_sequencer #(.NUM_FU(4), .DATA_W(32), .TAG_W(5), .TIMEOUT(8), .TMO_W(8))
      u_dut_b (.clk(clk), .rst(rst), .bus(bif_b));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic cpl_t mk(input logic [4:0] tag, input logic [31:0] res,
                               input logic [3:0] fu, input logic excp, input logic tmo);
      return {tag, res, fu, excp, tmo};
   endfunction

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      issue_sel   = 4'b0000;
      issue_tag   = 5'd0;
      issue_excp  = 1'b0;
      flush       = 1'b0;
      fu_done     = 4'b0000;
   endtask

   task automatic issue(input logic [3:0] sel, input logic [4:0] tag, input logic excp);
      issue_valid = 1'b1;
      issue_sel   = sel;
      issue_tag   = tag;
      issue_excp  = excp;
   endtask

   task automatic push_both(input cpl_t c);
      q_a.push_back(c);
      q_b.push_back(c);
   endtask

   // Monitor A: stability while stalled, scoreboard pop on each handshake.
   always @(negedge clk) begin
      got_a = {bif_a.done_tag_o, bif_a.done_result_o, bif_a.done_fu_o,
               bif_a.done_excp_o, bif_a.done_timeout_o};
      if (rst) begin
         hold_a = 1'b0;
      end else begin
         if (hold_a) check("a_hold_stable", 64'(got_a), 64'(prev_a));
         hold_a = bif_a.done_valid_o && !done_ready;
         prev_a = got_a;
         if (bif_a.done_valid_o && done_ready) begin
            $display("[%0t] cpl A tag=%0d result=%h fu=%b excp=%b tmo=%b", $time,
                     got_a.tag, got_a.res, got_a.fu, got_a.excp, got_a.tmo);
            if (q_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_cpl: got %0h, expected none", got_a);
            end else begin
               exp_a = q_a.pop_front();
               check("a_cpl", 64'(got_a), 64'(exp_a));
            end
         end
      end
   end

   always @(negedge clk) begin
      got_b = {bif_b.done_tag_o, bif_b.done_result_o, bif_b.done_fu_o,
               bif_b.done_excp_o, bif_b.done_timeout_o};
      if (rst) begin
         hold_b = 1'b0;
      end else begin
         if (hold_b) check("b_hold_stable", 64'(got_b), 64'(prev_b));
         hold_b = bif_b.done_valid_o && !done_ready;
         prev_b = got_b;
         if (bif_b.done_valid_o && done_ready) begin
            $display("[%0t] cpl B tag=%0d result=%h fu=%b excp=%b tmo=%b", $time,
                     got_b.tag, got_b.res, got_b.fu, got_b.excp, got_b.tmo);
            if (q_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected_cpl: got %0h, expected none", got_b);
            end else begin
               exp_b = q_b.pop_front();
               check("b_cpl", 64'(got_b), 64'(exp_b));
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got no finish, expected finish before 50000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      done_ready = 1'b1;
      fu_result  = '0;
      idle();
      repeat (3) next();
      neg();
      check("rst_issue_ready", bif_a.issue_ready_o, 0);
      check("rst_busy", bif_a.busy_o, 0);
      check("rst_start", bif_a.fu_start_o, 0);
      next(); rst = 1'b0;
      neg();
      check("post_rst_ready_a", bif_a.issue_ready_o, 1);
      check("post_rst_ready_b", bif_b.issue_ready_o, 1);
      check("post_rst_valid", bif_a.done_valid_o, 0);

      // Single-cycle unit
      next(); issue(4'b0001, 5'd5, 1'b0);
      push_both(mk(5'd5, 32'h1234, 4'b0001, 1'b0, 1'b0));
      neg(); check("t1_ready", bif_a.issue_ready_o, 1);
      next(); idle(); fu_done = 4'b0001; fu_result[31:0] = 32'h1234;
      neg(); check("t1_start", bif_a.fu_start_o, 4'b0001);
      check("t1_valid_early", bif_a.done_valid_o, 0);
      next(); fu_done = 4'b0000;
      neg(); check("t1_valid_t2", bif_a.done_valid_o, 1);
      next(); neg(); check("t1_idle", bif_a.busy_o, 0);

      // Multi-cycle unit with stalled consumer; B times out at 8 cycles
      next(); issue(4'b0100, 5'd9, 1'b0);
      q_a.push_back(mk(5'd9, 32'hDEADBEEF, 4'b0100, 1'b0, 1'b0));
      q_b.push_back(mk(5'd9, 32'h0, 4'b0100, 1'b0, 1'b1));
      next(); idle(); done_ready = 1'b0;
      neg(); check("t2_start", bif_a.fu_start_o, 4'b0100);
      next(); neg(); check("t2_single_pulse", bif_a.fu_start_o, 0);
      check("t2_busy", bif_a.busy_o, 1);
      repeat (7) next();
      neg(); check("t2_b_timeout_valid", bif_b.done_valid_o, 1);
      check("t2_a_waiting", bif_a.done_valid_o, 0);
      next(); fu_done = 4'b0100; fu_result[95:64] = 32'hDEADBEEF;
      next(); fu_done = 4'b0000;
      neg(); check("t2_a_valid", bif_a.done_valid_o, 1);
      check("t2_stall_ready", bif_a.issue_ready_o, 0);
      next(); next();
      neg(); check("t2_a_still_valid", bif_a.done_valid_o, 1);
      next(); done_ready = 1'b1; issue(4'b0000, 5'd3, 1'b0);
      push_both(mk(5'd3, 32'h0, 4'b0000, 1'b0, 1'b0));
      neg(); check("t2_b2b_ready", bif_a.issue_ready_o, 1);
      next(); idle();
      neg(); check("t2_noop_valid", bif_a.done_valid_o, 1);
      next();

      // Exception, then multi-hot back-to-back
      next(); issue(4'b0010, 5'd7, 1'b1);
      push_both(mk(5'd7, 32'h0, 4'b0000, 1'b1, 1'b0));
      next(); issue(4'b0011, 5'd8, 1'b0);
      push_both(mk(5'd8, 32'h0, 4'b0000, 1'b1, 1'b0));
      neg(); check("t3_excp_valid", bif_a.done_valid_o, 1);
      check("t3_excp_no_start", bif_a.fu_start_o, 0);
      check("t3_b2b_ready", bif_a.issue_ready_o, 1);
      next(); idle();
      neg(); check("t3_mh_no_start", bif_a.fu_start_o, 0);
      check("t3_mh_valid", bif_a.done_valid_o, 1);
      next();

      // Timeout on B; A finishes later and B ignores the stale done
      next(); issue(4'b1000, 5'd12, 1'b0);
      q_b.push_back(mk(5'd12, 32'h0, 4'b1000, 1'b0, 1'b1));
      next(); idle();
      repeat (7) next();
      neg(); check("t4_b_not_yet", bif_b.done_valid_o, 0);
      next(); neg(); check("t4_b_expired", bif_b.done_valid_o, 1);
      next(); fu_done = 4'b1000; fu_result[127:96] = 32'hCAFE0001;
      q_a.push_back(mk(5'd12, 32'hCAFE0001, 4'b1000, 1'b0, 1'b0));
      next(); fu_done = 4'b0000;
      neg(); check("t4_a_valid", bif_a.done_valid_o, 1);
      check("t4_b_stale_ignored", bif_b.done_valid_o, 0);
      check("t4_b_idle", bif_b.busy_o, 0);
      next();

      // Done on the expiry cycle of B: done wins
      next(); issue(4'b0010, 5'd14, 1'b0);
      push_both(mk(5'd14, 32'h0BADF00D, 4'b0010, 1'b0, 1'b0));
      next(); idle();
      repeat (6) next();
      next(); fu_done = 4'b0010; fu_result[63:32] = 32'h0BADF00D;
      next(); fu_done = 4'b0000;
      neg(); check("t5_b_valid", bif_b.done_valid_o, 1);
      check("t5_b_no_timeout", bif_b.done_timeout_o, 0);
      next();

      // Flush in WAIT, stale done afterwards
      next(); issue(4'b0001, 5'd2, 1'b0);
      next(); idle();
      next();
      next(); flush = 1'b1;
      neg(); check("t6_flush_ready", bif_a.issue_ready_o, 0);
      next(); flush = 1'b0; fu_done = 4'b0001;
      neg(); check("t6_idle_after_flush", bif_a.busy_o, 0);
      next(); fu_done = 4'b0000;
      neg(); check("t6_stale_no_valid", bif_a.done_valid_o, 0);

      // Flush beats a same-cycle issue
      next(); flush = 1'b1; issue(4'b0001, 5'd4, 1'b0);
      neg(); check("t6_flush_blocks_issue", bif_a.issue_ready_o, 0);
      next(); idle();
      neg(); check("t6_not_accepted", bif_a.busy_o, 0);
      check("t6_no_start", bif_a.fu_start_o, 0);

      // Flush in the START cycle squashes the pulse
      next(); issue(4'b0100, 5'd11, 1'b0);
      next(); idle(); flush = 1'b1;
      neg(); check("t6_start_suppressed", bif_a.fu_start_o, 0);
      next(); flush = 1'b0;
      neg(); check("t6_start_flush_idle", bif_a.busy_o, 0);

      // Reset mid-WAIT
      next(); issue(4'b0100, 5'd6, 1'b0);
      next(); idle();
      next();
      next(); rst = 1'b1;
      neg(); check("t7_rst_ready", bif_a.issue_ready_o, 0);
      next(); rst = 1'b0;
      neg();
      check("t7_busy", bif_a.busy_o, 0);
      check("t7_valid", bif_a.done_valid_o, 0);
      check("t7_start", bif_a.fu_start_o, 0);
      check("t7_tag", bif_a.done_tag_o, 0);
      check("t7_result", bif_a.done_result_o, 0);
      check("t7_ready", bif_a.issue_ready_o, 1);
      next();

      check("queue_a_drained", q_a.size(), 0);
      check("queue_b_drained", q_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
